updown_counter_mod: RTL and testbench

- Parametrised successor to the 8-bit up/down counter.
- Generalises width and count modulus.
- Adds enable, synchronous clear, parallel load, wrap/saturate mode selection, terminal-count output for cascading, and registered overflow/underflow/load-error flags.
- Used as a generic building block for timers, BCD digit chains and address counters in the course datapaths.

---
 rtl/updown_counter_mod_if.sv | 27 ++
 rtl/updown_counter_mod.sv | 105 ++++++++++
 tb/tb_updown_counter_mod.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/updown_counter_mod_if.sv
// Control and status bundle for updown_counter_mod.
// The master drives the count controls and the load value.
// The slave returns the count, the terminal count and the event flags.
interface updown_counter_mod_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             m;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             ovf;
  logic             unf;
  logic             lerr;

  modport master (
    output en, m, clr, load, d,
    input  q, tc, ovf, unf, lerr
  );

  modport slave (
    input  en, m, clr, load, d,
    output q, tc, ovf, unf, lerr
  );
endinterface

// File: rtl/updown_counter_mod.sv
// Parametrised modulo-(MAX+1) up/down counter.
// Features: enable, synchronous clear, parallel load with range check,
// wrap or saturate at the limits, and a terminal-count output for cascading.
// Flags ovf/unf/lerr are registered one-cycle pulses.
// Priority at each edge: clr, then load, then the count enable.
module updown_counter_mod #(
  parameter int WIDTH    = 8,
  parameter int MAX      = 2**WIDTH - 1,
  parameter int SATURATE = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  updown_counter_mod_if.slave  bus
);

  localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] q_q,    q_d;
  logic             ovf_q,  ovf_d;
  logic             unf_q,  unf_d;
  logic             lerr_q, lerr_d;

  // Terminal count: the value at which the next enabled count crosses a limit.
  function automatic logic term_count(input logic [WIDTH-1:0] cnt, input logic up);
    logic res;
    if (up) begin
      res = (cnt == MAX_C);
    end else begin
      res = (cnt == ZERO_C);
    end
    return res;
  endfunction

  // Value reached from a limit: wrap to the opposite limit, or stay put.
  function automatic logic [WIDTH-1:0] limit_next(input logic [WIDTH-1:0] cnt,
                                                  input logic [WIDTH-1:0] wrap_to);
    logic [WIDTH-1:0] res;
    if (SATURATE != 0) begin
      res = cnt;
    end else begin
      res = wrap_to;
    end
    return res;
  endfunction

  // Next-state selection: clr over load over count; flags default low so they pulse.
  always_comb begin
    q_d    = q_q;
    ovf_d  = 1'b0;
    unf_d  = 1'b0;
    lerr_d = 1'b0;
    if (bus.clr) begin
      q_d = ZERO_C;
    end else if (bus.load) begin
      if (bus.d > MAX_C) begin
        q_d    = MAX_C;
        lerr_d = 1'b1;
      end else begin
        q_d = bus.d;
      end
    end else if (bus.en) begin
      if (bus.m) begin
        if (q_q == MAX_C) begin
          q_d   = limit_next(q_q, ZERO_C);
          ovf_d = 1'b1;
        end else begin
          q_d = q_q + ONE_C;
        end
      end else begin
        if (q_q == ZERO_C) begin
          q_d   = limit_next(q_q, MAX_C);
          unf_d = 1'b1;
        end else begin
          q_d = q_q - ONE_C;
        end
      end
    end else begin
      q_d = q_q;
    end
  end

  // Count and flag registers; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q    <= ZERO_C;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
      lerr_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
      lerr_q <= lerr_d;
    end
  end

  assign bus.q    = q_q;
  assign bus.tc   = term_count(q_q, bus.m);
  assign bus.ovf  = ovf_q;
  assign bus.unf  = unf_q;
  assign bus.lerr = lerr_q;

endmodule

// File: tb/tb_updown_counter_mod.sv
// Scoreboard bench for updown_counter_mod: wrap (8-bit and mod-10),
// saturating mod-10, and a two-digit decimal cascade, all driven together.
module tb_updown_counter_mod;

  typedef struct packed {
    logic [7:0] q;
    logic       tc;
    logic       ovf;
    logic       unf;
    logic       lerr;
  } obs_t;

  typedef struct packed {
    logic [3:0] hq;
    logic [3:0] lq;
    logic       hovf;
    logic       hunf;
    logic       lovf;
    logic       lunf;
  } cas_t;

  logic clk;
  logic rst;
  logic cen;

  int pass_cnt  = 0;
  int total_cnt = 0;

  obs_t qa[$];
  obs_t qb[$];
  obs_t qc[$];
  cas_t qk[$];

  // Reference state: plain integers
  int va, vb, vc, vk;

  updown_counter_mod_if #(.WIDTH(8)) ifa ();
  updown_counter_mod_if #(.WIDTH(4)) ifb ();
  updown_counter_mod_if #(.WIDTH(4)) ifc ();
  updown_counter_mod_if #(.WIDTH(4)) ifl ();
  updown_counter_mod_if #(.WIDTH(4)) ifh ();

  updown_counter_mod #(.WIDTH(8), .MAX(255), .SATURATE(0)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  updown_counter_mod #(.WIDTH(4), .MAX(9),   .SATURATE(0)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));
  updown_counter_mod #(.WIDTH(4), .MAX(9),   .SATURATE(1)) dut_c (.clk(clk), .rst(rst), .bus(ifc.slave));
  updown_counter_mod #(.WIDTH(4), .MAX(9),   .SATURATE(0)) dut_l (.clk(clk), .rst(rst), .bus(ifl.slave));
  updown_counter_mod #(.WIDTH(4), .MAX(9),   .SATURATE(0)) dut_h (.clk(clk), .rst(rst), .bus(ifh.slave));

  // Cascade: high digit steps only when the low digit is enabled at its terminal count
  assign ifh.en = ifl.en & ifl.tc;
  assign ifh.m  = ifl.m;
  assign ifh.clr = ifl.clr;
  assign ifh.load = 1'b0;
  assign ifh.d  = 4'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  // Counter behaviour from its rules; updates value, returns the flags
  task automatic model(input int mx, input bit sat, input bit e, input bit mm, input bit c,
                       input bit l, input int dv, inout int v,
                       output bit ovf, output bit unf, output bit lerr);
    ovf = 1'b0; unf = 1'b0; lerr = 1'b0;
    if (c) v = 0;
    else if (l) begin
      if (dv > mx) begin v = mx; lerr = 1'b1; end
      else v = dv;
    end else if (e) begin
      if (mm) begin
        if (v == mx) begin ovf = 1'b1; v = sat ? mx : 0; end
        else v = v + 1;
      end else begin
        if (v == 0) begin unf = 1'b1; v = sat ? 0 : mx; end
        else v = v - 1;
      end
    end
  endtask

  function automatic obs_t mk(input int v, input int mx, input bit mm,
                              input bit o, input bit u, input bit le);
    obs_t r;
    r.q    = 8'(v);
    r.tc   = mm ? (v == mx) : (v == 0);
    r.ovf  = o;
    r.unf  = u;
    r.lerr = le;
    return r;
  endfunction

  // One clock of stimulus; expected post-edge outputs go to the scoreboard
  task automatic step(input bit r, input bit e, input bit mm, input bit c, input bit l,
                      input logic [7:0] dv, input bit ce);
    bit o, u, le;
    cas_t k;
    @(posedge clk);
    #2;
    rst = r;
    ifa.en = e; ifa.m = mm; ifa.clr = c; ifa.load = l; ifa.d = dv;
    ifb.en = e; ifb.m = mm; ifb.clr = c; ifb.load = l; ifb.d = dv[3:0];
    ifc.en = e; ifc.m = mm; ifc.clr = c; ifc.load = l; ifc.d = dv[3:0];
    ifl.en = ce; ifl.m = mm; ifl.clr = c; ifl.load = 1'b0; ifl.d = 4'd0;
    cen = ce;
    k = '0;
    if (!r) begin
      va = 0; vb = 0; vc = 0; vk = 0;
      qa.push_back(mk(0, 255, mm, 1'b0, 1'b0, 1'b0));
      qb.push_back(mk(0, 9, mm, 1'b0, 1'b0, 1'b0));
      qc.push_back(mk(0, 9, mm, 1'b0, 1'b0, 1'b0));
    end else begin
      model(255, 1'b0, e, mm, c, l, int'(dv), va, o, u, le);
      qa.push_back(mk(va, 255, mm, o, u, le));
      model(9, 1'b0, e, mm, c, l, int'(dv[3:0]), vb, o, u, le);
      qb.push_back(mk(vb, 9, mm, o, u, le));
      model(9, 1'b1, e, mm, c, l, int'(dv[3:0]), vc, o, u, le);
      qc.push_back(mk(vc, 9, mm, o, u, le));
      // Two-digit decimal count 0..99
      if (c) vk = 0;
      else if (ce) begin
        if (mm) begin
          k.lovf = (vk % 10 == 9);
          k.hovf = (vk == 99);
          vk = (vk + 1) % 100;
        end else begin
          k.lunf = (vk % 10 == 0);
          k.hunf = (vk == 0);
          vk = (vk + 99) % 100;
        end
      end
    end
    k.hq = 4'(vk / 10);
    k.lq = 4'(vk % 10);
    qk.push_back(k);
  endtask

  // Reset dropped between edges must clear outputs without waiting for a clock
  task automatic async_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    va = 0; vb = 0; vc = 0; vk = 0;
    #1;
    chk("async_a", {ifa.q, ifa.ovf, ifa.unf, ifa.lerr}, 32'd0);
    chk("async_b", {ifb.q, ifb.ovf, ifb.unf, ifb.lerr}, 32'd0);
    chk("async_c", {ifc.q, ifc.ovf, ifc.unf, ifc.lerr}, 32'd0);
    chk("async_k", {ifh.q, ifl.q, ifh.ovf, ifl.ovf}, 32'd0);
  endtask

  // Monitor: counters present a result every cycle; compare just after each edge
  initial begin
    obs_t e;
    cas_t k;
    forever begin
      @(posedge clk);
      #1;
      if (rst === 1'b1 && $isunknown({ifa.en, ifa.m, ifl.en, ifl.m})) begin
        chk("x_ctrl", 32'd1, 32'd0);
      end
      if (qa.size() > 0) begin
        e = qa.pop_front();
        chk("w8_255", 32'({ifa.q, ifa.tc, ifa.ovf, ifa.unf, ifa.lerr}), 32'(e));
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        chk("w4_9_wrap", 32'({4'd0, ifb.q, ifb.tc, ifb.ovf, ifb.unf, ifb.lerr}), 32'(e));
      end
      if (qc.size() > 0) begin
        e = qc.pop_front();
        chk("w4_9_sat", 32'({4'd0, ifc.q, ifc.tc, ifc.ovf, ifc.unf, ifc.lerr}), 32'(e));
      end
      if (qk.size() > 0) begin
        k = qk.pop_front();
        chk("cascade", 32'({ifh.q, ifl.q, ifh.ovf, ifh.unf, ifl.ovf, ifl.unf}), 32'(k));
      end
    end
  end

  // Stimulus: directed scenarios, then random traffic
  initial begin
    rst = 1'b0; cen = 1'b0;
    ifa.en = 1'b0; ifa.m = 1'b1; ifa.clr = 1'b0; ifa.load = 1'b0; ifa.d = 8'd0;
    ifb.en = 1'b0; ifb.m = 1'b1; ifb.clr = 1'b0; ifb.load = 1'b0; ifb.d = 4'd0;
    ifc.en = 1'b0; ifc.m = 1'b1; ifc.clr = 1'b0; ifc.load = 1'b0; ifc.d = 4'd0;
    ifl.en = 1'b0; ifl.m = 1'b1; ifl.clr = 1'b0; ifl.load = 1'b0; ifl.d = 4'd0;
    va = 0; vb = 0; vc = 0; vk = 0;

    // Reset state held across edges
    repeat (3) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1);

    // Full 8-bit up sweep with wrap and ovf
    repeat (257) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);

    // Mod-10 down from 0 then up through 9
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0);
    repeat (4) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    repeat (12) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);

    // Saturation: load 8, up x4, then down
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd8, 1'b0);
    repeat (4) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);

    // Load out of range, clr beats load, load beats count
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd12, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd12, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'd3, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);

    // Async reset mid-count from 0x5A, hold, release
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h5A, 1'b1);
    repeat (2) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1);
    async_reset();
    repeat (3) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1);
    repeat (2) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);

    // Cascade: 100 edges back to 00, then 47 more
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0);
    repeat (100) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1);
    repeat (47) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1);
    repeat (60) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1);

    // Random traffic, direction held in runs to reach the limits
    begin
      bit mm;
      mm = 1'b1;
      for (int i = 0; i < 2000; i++) begin
        if ($urandom_range(0, 7) == 0) mm = ~mm;
        step(($urandom_range(0, 99) != 0),
             ($urandom_range(0, 3) != 0),
             mm,
             ($urandom_range(0, 31) == 0),
             ($urandom_range(0, 9) == 0),
             8'($urandom_range(0, 255)),
             ($urandom_range(0, 3) != 0));
      end
    end

    repeat (2) @(posedge clk);
    #3;
    chk("drain", 32'(qa.size() + qb.size() + qc.size() + qk.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
